// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit pin between NREQ byte
// sources, with pin_cts flow control sampled only between frames.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned CLKS_PER_BIT = 260,
    localparam int unsigned GW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pin_cts,
    output logic              pin_tx,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              busy,
    output logic [GW-1:0]     grant_id
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            pin_tx_q, pin_tx_d;
    logic            busy_q, busy_d;
    logic            cts_s1_q, cts_s2_q;

    logic [GW-1:0]   winner;
    logic [GW-1:0]   scan_idx;
    logic [31:0]     scan_sum;
    logic            found;
    logic            accept;
    logic            baud_wrap;

    // Round-robin scan starting just after the last winner
    always_comb begin
        winner   = ptr_q;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_sum = 32'(ptr_q) + 32'(k);
            scan_idx = GW'(scan_sum % NREQ);
            if (!found && req_valid[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Synchronised CTS is only consulted while the line is idle
    assign accept    = (state_q == IDLE) && !cts_s2_q && (|req_valid);
    assign req_ready = accept ? (NREQ'(1) << winner) : '0;
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        pin_tx_d = 1'b1;
        busy_d   = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = req_data[32'(winner)*8 +: 8];
                    ptr_d   = winner;
                    grant_d = winner;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so pin_tx stays a flop
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   pin_tx_d = 1'b0;
            DATA:    pin_tx_d = shift_d[bit_d];
            default: pin_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            ptr_q    <= GW'(NREQ - 1);
            grant_q  <= '0;
            pin_tx_q <= 1'b1;
            busy_q   <= 1'b0;
            cts_s1_q <= 1'b1;
            cts_s2_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            pin_tx_q <= pin_tx_d;
            busy_q   <= busy_d;
            cts_s1_q <= pin_cts;
            cts_s2_q <= cts_s1_q;
        end
    end

    assign pin_tx   = pin_tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench: a transaction-level predictor queues expected
// frames; an independent line monitor decodes pin_tx and compares.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned CPB   = 4;
    localparam int unsigned GW    = 1;
    localparam int unsigned FRAME = 10 * CPB;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pin_cts = 1'b1;
    logic              pin_tx;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              busy;
    logic [GW-1:0]     grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .pin_cts(pin_cts), .pin_tx(pin_tx),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        int         start;
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int   m_ptr   = NREQ - 1;
    int   m_free  = 0;
    int   m_acc_n = 0;
    int   last_w  = -1;
    logic cts_h1  = 1'b1;
    logic cts_h2  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] d);
        logic [9:0] bits;
        logic [FRAME-1:0] w;
        bits = {1'b1, d, 1'b0};
        for (int k = 0; k < int'(FRAME); k++) w[k] = bits[k / int'(CPB)];
        return w;
    endfunction

    // Predict which requester (if any) must be accepted this cycle
    task automatic predict();
        logic [NREQ-1:0] exp_rdy;
        int w;
        exp_rdy = '0;
        w = -1;
        if (!rst_n) begin
            check("ready_in_reset", 64'(req_ready), 64'(0));
            cts_h1 = 1'b1;
            cts_h2 = 1'b1;
        end else begin
            if (cyc >= m_free && cts_h2 == 1'b0 && req_valid != '0) begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    int i;
                    i = (m_ptr + k) % int'(NREQ);
                    if (w < 0 && req_valid[i]) w = i;
                end
                exp_rdy[w] = 1'b1;
            end
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (w >= 0) begin
                exp_q.push_back('{w, req_data[8*w +: 8], cyc + 1});
                m_ptr  = w;
                m_free = cyc + int'(FRAME) + 1;
                m_acc_n++;
            end
            cts_h2 = cts_h1;
            cts_h1 = pin_cts;
        end
        last_w = w;
    endtask

    task automatic step();
        @(negedge clk);
        predict();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_accept(input int max_cyc);
        int start_n;
        int waited;
        start_n = m_acc_n;
        waited = 0;
        while (m_acc_n == start_n && waited < max_cyc) begin
            step();
            waited++;
        end
        if (m_acc_n == start_n) check("accept_timeout", 64'(0), 64'(1));
    endtask

    // Line monitor: decode each frame and compare against the scoreboard
    bit               mon_act = 1'b0;
    int               mon_cnt = 0;
    logic [FRAME-1:0] obs_tx;
    logic [FRAME-1:0] obs_busy;
    frame_t           cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (mon_act) begin
            obs_tx[mon_cnt]   = pin_tx;
            obs_busy[mon_cnt] = busy;
            mon_cnt++;
            if (mon_cnt == int'(FRAME)) begin
                mon_act = 1'b0;
                check("frame_wave", 64'(obs_tx), 64'(exp_wave(cur.data)));
                check("frame_busy", 64'(obs_busy), 64'({FRAME{1'b1}}));
            end
        end else if (pin_tx == 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'(1), 64'(0));
            end else begin
                cur = exp_q.pop_front();
                check("frame_start_cycle", 64'(cyc), 64'(cur.start));
                check("grant_id", 64'(grant_id), 64'(cur.id));
                obs_tx[0]   = pin_tx;
                obs_busy[0] = busy;
                mon_cnt     = 1;
                mon_act     = 1'b1;
            end
        end else begin
            check("idle_busy", 64'(busy), 64'(0));
        end
    end

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check("rst_pin_tx", 64'(pin_tx), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        exp_q.delete();
        m_ptr  = NREQ - 1;
        m_free = 0;
        cts_h1 = 1'b1;
        cts_h2 = 1'b1;
        @(posedge clk);
        #1;
        run(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        apply_reset(2);

        // Single byte 0xA5 from requester 0
        pin_cts   = 1'b0;
        req_data  = {8'h00, 8'hA5};
        req_valid = 2'b01;
        run_until_accept(10);
        req_valid = 2'b00;
        run(FRAME + 5);

        // Continuous contention: frames alternate 0x11, 0x22
        req_data  = {8'h22, 8'h11};
        req_valid = 2'b11;
        run(4 * (FRAME + 1) + 2);
        req_valid = 2'b00;
        run(FRAME + 5);

        // CTS held off: requester 1 must wait, then go within 3 cycles
        pin_cts   = 1'b1;
        req_data  = {8'h3C, 8'h00};
        req_valid = 2'b10;
        run(60);
        pin_cts = 1'b0;
        run_until_accept(3);
        req_valid = 2'b00;

        // CTS raised during bit 3 of the frame in flight
        run(4 * CPB);
        pin_cts   = 1'b1;
        req_data  = {8'h00, 8'h96};
        req_valid = 2'b01;
        run(2 * FRAME);
        pin_cts = 1'b0;
        run_until_accept(5);
        req_valid = 2'b00;

        // One-cycle request pulse while busy is ignored
        run(2 * CPB);
        req_data  = {8'h00, 8'hEE};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        run(FRAME + 5);

        // Reset in the middle of DATA, then both request: requester 0 first
        req_data  = {8'h00, 8'h5A};
        req_valid = 2'b01;
        run_until_accept(5);
        req_valid = 2'b00;
        run(4 * CPB);
        apply_reset(2);
        req_data  = {8'h77, 8'h66};
        req_valid = 2'b11;
        run_until_accept(10);
        req_valid = 2'b00;
        run(FRAME + 5);

        // Randomised traffic with valid drop-outs and CTS toggling
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (last_w == i || $urandom_range(0, 15) == 0) begin
                    req_valid[i]      = 1'($urandom_range(0, 1));
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 63) == 0) pin_cts = ~pin_cts;
            step();
        end
        req_valid = '0;
        run(FRAME + 10);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("monitor_idle", 64'(mon_act), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
